vending_ctrl_seq: RTL and testbench

//  Clocked, parametrised vending controller: accepts coin/bill pulses, holds credit, checks

---
 rtl/vending_ctrl_seq.sv | 180 ++++++++++++++++++
 tb/tb_vending_ctrl_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl_seq.sv
// Vending controller: accumulates coin credit, checks selections against a
// price table, pulses a vend, then pays change back one coin at a time.
module vending_ctrl_seq #(
  parameter int N_ITEMS        = 9,
  parameter int MONEY_W        = 10,
  parameter int MAX_CREDIT     = 500,
  parameter int PRICE_SHOW_CYC = 50
) (
  input  logic                         clk,
  input  logic                         cancelReset,
  input  logic [N_ITEMS*MONEY_W-1:0]   prices,
  input  logic                         coin_valid,
  input  logic [2:0]                   coin_type,
  input  logic                         sel_valid,
  input  logic [$clog2(N_ITEMS)-1:0]   sel_idx,
  input  logic                         cancel,
  output logic [MONEY_W-1:0]           credit,
  output logic                         coin_reject,
  output logic [N_ITEMS-1:0]           gled,
  output logic [N_ITEMS-1:0]           rled,
  output logic                         vend_valid,
  output logic [$clog2(N_ITEMS)-1:0]   vend_idx,
  output logic                         chg_valid,
  output logic [1:0]                   chg_coin,
  input  logic                         chg_ready,
  output logic [MONEY_W-1:0]           disp_value
);

  localparam int IDX_W = $clog2(N_ITEMS);
  localparam int CNT_W = $clog2(PRICE_SHOW_CYC + 1);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t             state;
  logic [MONEY_W-1:0] showPrice;
  logic [CNT_W-1:0]   showCnt;
  logic [MONEY_W-1:0] selPrice;
  logic [MONEY_W:0]   coinVal;
  logic               inService;
  logic               coinTaken;
  logic [MONEY_W-1:0] chgRemain;

  // Accepted coin value in cents; zero marks an unrecognised coin code.
  function automatic logic [MONEY_W:0] coinValue(input logic [2:0] t);
    case (t)
      3'd0:    return (MONEY_W+1)'(5);
      3'd1:    return (MONEY_W+1)'(10);
      3'd2:    return (MONEY_W+1)'(25);
      3'd3:    return (MONEY_W+1)'(50);
      3'd4:    return (MONEY_W+1)'(100);
      3'd5:    return (MONEY_W+1)'(500);
      default: return '0;
    endcase
  endfunction

  // Price lookup; indices beyond the table read as out of stock.
  function automatic logic [MONEY_W-1:0] priceOf(input logic [N_ITEMS*MONEY_W-1:0] tbl,
                                                  input logic [IDX_W-1:0] idx);
    logic [MONEY_W-1:0] p;
    p = '0;
    for (int k = 0; k < N_ITEMS; k++)
      if (idx == IDX_W'(k)) p = tbl[k*MONEY_W +: MONEY_W];
    return p;
  endfunction

  // Largest change coin that still fits in the remaining credit.
  function automatic logic [1:0] greedyCoin(input logic [MONEY_W-1:0] c);
    if (c >= MONEY_W'(100))     return 2'd3;
    else if (c >= MONEY_W'(25)) return 2'd2;
    else if (c >= MONEY_W'(10)) return 2'd1;
    else                        return 2'd0;
  endfunction

  function automatic logic [MONEY_W-1:0] chgValue(input logic [1:0] code);
    case (code)
      2'd0:    return MONEY_W'(5);
      2'd1:    return MONEY_W'(10);
      2'd2:    return MONEY_W'(25);
      default: return MONEY_W'(100);
    endcase
  endfunction

  assign selPrice  = priceOf(prices, sel_idx);
  assign coinVal   = coinValue(coin_type);
  assign inService = (state == IDLE) || (state == CREDIT);
  // A coin is only taken when nothing of higher priority happens this cycle.
  assign coinTaken = coin_valid && inService && !cancel && !sel_valid && (coinVal != '0) &&
                     (({1'b0, credit} + coinVal) <= (MONEY_W+1)'(MAX_CREDIT));
  assign chgRemain = credit - chgValue(chg_coin);
  assign disp_value = (showCnt != '0) ? showPrice : credit;

  // Item LEDs follow the price table and the registered credit.
  always_comb begin
    gled = '0;
    rled = '0;
    for (int k = 0; k < N_ITEMS; k++) begin
      rled[k] = (prices[k*MONEY_W +: MONEY_W] == '0);
      gled[k] = !rled[k] && (credit >= prices[k*MONEY_W +: MONEY_W]);
    end
  end

  // Controller FSM with registered pulses, credit, change and price-show timer.
  always_ff @(posedge clk or posedge cancelReset) begin
    if (cancelReset) begin
      state       <= IDLE;
      credit      <= '0;
      showPrice   <= '0;
      showCnt     <= '0;
      coin_reject <= 1'b0;
      vend_valid  <= 1'b0;
      vend_idx    <= '0;
      chg_valid   <= 1'b0;
      chg_coin    <= '0;
    end else begin
      coin_reject <= coin_valid && !coinTaken;
      vend_valid  <= 1'b0;
      if (showCnt != '0) showCnt <= showCnt - CNT_W'(1);
      case (state)
        IDLE, CREDIT: begin
          if (cancel) begin
            if (state == CREDIT) begin
              showCnt <= '0;
              if (credit >= MONEY_W'(5)) begin
                state     <= CHANGE;
                chg_valid <= 1'b1;
                chg_coin  <= greedyCoin(credit);
              end else begin
                state  <= IDLE;
                credit <= '0;
              end
            end
          end else if (sel_valid) begin
            if (selPrice != '0) begin
              if (selPrice > credit) begin
                showPrice <= selPrice;
                showCnt   <= CNT_W'(PRICE_SHOW_CYC);
              end else begin
                state      <= VEND;
                vend_valid <= 1'b1;
                vend_idx   <= sel_idx;
                credit     <= credit - selPrice;
                showCnt    <= '0;
              end
            end
          end else if (coinTaken) begin
            credit  <= credit + coinVal[MONEY_W-1:0];
            state   <= CREDIT;
            showCnt <= '0;
          end
        end
        VEND: begin
          if (credit >= MONEY_W'(5)) begin
            state     <= CHANGE;
            chg_valid <= 1'b1;
            chg_coin  <= greedyCoin(credit);
          end else begin
            state  <= IDLE;
            credit <= '0;
          end
        end
        default: begin
          if (!chg_valid) begin
            state  <= IDLE;
            credit <= '0;
          end else if (chg_ready) begin
            if (chgRemain >= MONEY_W'(5)) begin
              credit   <= chgRemain;
              chg_coin <= greedyCoin(chgRemain);
            end else begin
              credit    <= '0;
              chg_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_ctrl_seq.sv
// Bench for vending_ctrl_seq: directed scenarios plus random traffic, all
// compared cycle by cycle against a transaction-level money model.
module tb_vending_ctrl_seq;

  localparam int N_ITEMS        = 9;
  localparam int MONEY_W        = 10;
  localparam int MAX_CREDIT     = 500;
  localparam int PRICE_SHOW_CYC = 50;
  localparam int IDX_W          = $clog2(N_ITEMS);

  logic                       clk = 1'b0;
  logic                       cancelReset;
  logic [N_ITEMS*MONEY_W-1:0] prices;
  logic                       coin_valid;
  logic [2:0]                 coin_type;
  logic                       sel_valid;
  logic [IDX_W-1:0]           sel_idx;
  logic                       cancel;
  logic [MONEY_W-1:0]         credit;
  logic                       coin_reject;
  logic [N_ITEMS-1:0]         gled;
  logic [N_ITEMS-1:0]         rled;
  logic                       vend_valid;
  logic [IDX_W-1:0]           vend_idx;
  logic                       chg_valid;
  logic [1:0]                 chg_coin;
  logic                       chg_ready;
  logic [MONEY_W-1:0]         disp_value;

  vending_ctrl_seq #(.N_ITEMS(N_ITEMS), .MONEY_W(MONEY_W), .MAX_CREDIT(MAX_CREDIT),
                     .PRICE_SHOW_CYC(PRICE_SHOW_CYC)) dut (
    .clk(clk), .cancelReset(cancelReset), .prices(prices),
    .coin_valid(coin_valid), .coin_type(coin_type), .sel_valid(sel_valid),
    .sel_idx(sel_idx), .cancel(cancel), .credit(credit), .coin_reject(coin_reject),
    .gled(gled), .rled(rled), .vend_valid(vend_valid), .vend_idx(vend_idx),
    .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ready(chg_ready),
    .disp_value(disp_value)
  );

  always #5 clk = ~clk;

  int priceTab [N_ITEMS] = '{100, 325, 0, 75, 150, 37, 250, 10, 495};
  int coinCents [8] = '{5, 10, 25, 50, 100, 500, 0, 0};
  int chgCents  [4] = '{5, 10, 25, 100};

  int nChecks = 0;
  int nErrors = 0;

  // Reference model: money and the list of change coins still owed.
  int mCredit, mShow, mShowPrice, mVendIdx;
  bit mVendCycle, mCoinReject, mVendValid;
  int chgQ[$];

  task automatic checkVal(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mCredit = 0; mShow = 0; mShowPrice = 0; mVendIdx = 0;
    mVendCycle = 0; mCoinReject = 0; mVendValid = 0;
    chgQ.delete();
  endtask

  // Split the credit into greedy change coins; the sub-5c residue stays in credit.
  task automatic startPayout();
    int c;
    c = mCredit;
    while (c >= 5) begin
      if (c >= 100)     begin chgQ.push_back(100); c -= 100; end
      else if (c >= 25) begin chgQ.push_back(25);  c -= 25;  end
      else if (c >= 10) begin chgQ.push_back(10);  c -= 10;  end
      else              begin chgQ.push_back(5);   c -= 5;   end
    end
    if (chgQ.size() == 0) mCredit = 0;
  endtask

  task automatic modelStep(input bit cv, input int ct, input bit sv, input int si,
                           input bit cn, input bit rdy);
    int p, v;
    mCoinReject = 0;
    mVendValid  = 0;
    if (mShow > 0) mShow--;
    if (chgQ.size() > 0) begin
      mCoinReject = cv;
      if (rdy) begin
        mCredit -= chgQ.pop_front();
        if (chgQ.size() == 0) mCredit = 0;
      end
    end else if (mVendCycle) begin
      mCoinReject = cv;
      mVendCycle  = 0;
      startPayout();
    end else if (cn) begin
      mCoinReject = cv;
      if (mCredit > 0) begin
        mShow = 0;
        startPayout();
      end
    end else if (sv) begin
      mCoinReject = cv;
      p = (si < N_ITEMS) ? priceTab[si] : 0;
      if (p != 0) begin
        if (p > mCredit) begin
          mShow = PRICE_SHOW_CYC; mShowPrice = p;
        end else begin
          mCredit -= p; mVendValid = 1; mVendIdx = si; mVendCycle = 1; mShow = 0;
        end
      end
    end else if (cv) begin
      v = coinCents[ct];
      if (v == 0 || mCredit + v > MAX_CREDIT) mCoinReject = 1;
      else begin
        mCredit += v; mShow = 0;
      end
    end
  endtask

  task automatic compareAll();
    logic [N_ITEMS-1:0] eg, er;
    for (int k = 0; k < N_ITEMS; k++) begin
      er[k] = (priceTab[k] == 0);
      eg[k] = (priceTab[k] != 0) && (mCredit >= priceTab[k]);
    end
    checkVal("credit", credit, mCredit);
    checkVal("coin_reject", coin_reject, mCoinReject);
    checkVal("vend_valid", vend_valid, mVendValid);
    if (mVendValid) checkVal("vend_idx", vend_idx, mVendIdx);
    checkVal("chg_valid", chg_valid, chgQ.size() > 0);
    if (chgQ.size() > 0) checkVal("chg_coin", chgCents[chg_coin], chgQ[0]);
    checkVal("disp_value", disp_value, (mShow > 0) ? mShowPrice : mCredit);
    checkVal("gled", gled, eg);
    checkVal("rled", rled, er);
  endtask

  // Called just after a falling edge: drive, advance the model, check next cycle.
  task automatic doCycle(input bit cv, input int ct, input bit sv, input int si,
                         input bit cn, input bit rdy);
    coin_valid = cv; coin_type = 3'(ct); sel_valid = sv; sel_idx = IDX_W'(si);
    cancel = cn; chg_ready = rdy;
    modelStep(cv, ct, sv, si, cn, rdy);
    @(negedge clk);
    compareAll();
  endtask

  task automatic idle(input bit rdy);
    doCycle(0, 0, 0, 0, 0, rdy);
  endtask

  task automatic coin(input int ct);
    doCycle(1, ct, 0, 0, 0, 1);
  endtask

  // Refund whatever is left and let the payout finish.
  task automatic clearOut();
    int guard;
    doCycle(0, 0, 0, 0, 1, 1);
    guard = 0;
    while ((chgQ.size() > 0 || mVendCycle) && guard < 100) begin
      idle(1);
      guard++;
    end
    checkVal("drain timeout", guard < 100, 1);
  endtask

  initial begin
    int showCount;
    int got[$];
    int expSeq [6] = '{100, 25, 25, 25, 10, 5};

    for (int k = 0; k < N_ITEMS; k++) prices[k*MONEY_W +: MONEY_W] = MONEY_W'(priceTab[k]);
    cancelReset = 1'b1;
    coin_valid = 0; coin_type = 0; sel_valid = 0; sel_idx = 0; cancel = 0; chg_ready = 0;
    modelReset();
    #2;
    checkVal("reset credit", credit, 0);
    checkVal("reset chg_valid", chg_valid, 0);
    checkVal("reset vend_valid", vend_valid, 0);
    checkVal("reset vend_idx", vend_idx, 0);
    checkVal("reset coin_reject", coin_reject, 0);
    checkVal("reset disp", disp_value, 0);
    @(negedge clk);
    cancelReset = 1'b0;

    // Two coins, vend a 100c item, one 25c coin of change.
    coin(4); coin(2);
    checkVal("T2 credit", credit, 125);
    doCycle(0, 0, 1, 0, 0, 1);
    checkVal("T2 vend", vend_valid, 1);
    checkVal("T2 vend_idx", vend_idx, 0);
    idle(1);
    checkVal("T2 chg_valid", chg_valid, 1);
    checkVal("T2 chg_coin", chg_coin, 2);
    idle(1);
    checkVal("T2 credit end", credit, 0);
    checkVal("T2 chg done", chg_valid, 0);

    // Credit limit: 475 + 50 rejected, 475 + 25 fills to 500.
    coin(4); coin(4); coin(4); coin(4); coin(3); coin(2);
    checkVal("T3 credit", credit, 475);
    coin(3);
    checkVal("T3 reject", coin_reject, 1);
    checkVal("T3 credit kept", credit, 475);
    coin(2);
    checkVal("T3 credit max", credit, 500);
    clearOut();

    // Price check from zero credit shows the price for the programmed time.
    showCount = 0;
    doCycle(0, 0, 1, 1, 0, 1);
    if (disp_value == 325) showCount++;
    repeat (PRICE_SHOW_CYC + 10) begin
      idle(1);
      if (disp_value == 325) showCount++;
    end
    checkVal("T4 show cycles", showCount, PRICE_SHOW_CYC);
    checkVal("T4 disp after", disp_value, 0);

    // 190c refund with the dispenser stalled for three cycles.
    coin(4); coin(3); coin(2); coin(1); coin(0);
    checkVal("T5 credit", credit, 190);
    doCycle(0, 0, 0, 0, 1, 0);
    repeat (3) begin
      checkVal("T5 stall coin", chg_coin, 3);
      checkVal("T5 stall valid", chg_valid, 1);
      idle(0);
    end
    for (int i = 0; i < 20 && chg_valid; i++) begin
      got.push_back(chgCents[chg_coin]);
      idle(1);
    end
    checkVal("T5 coin count", got.size(), 6);
    for (int i = 0; i < 6; i++)
      checkVal($sformatf("T5 coin%0d", i), (i < got.size()) ? got[i] : -1, expSeq[i]);

    // Coin and exact-price selection in the same cycle.
    coin(4);
    doCycle(1, 2, 1, 0, 0, 1);
    checkVal("T6 vend", vend_valid, 1);
    checkVal("T6 reject", coin_reject, 1);
    checkVal("T6 credit", credit, 0);
    idle(1);
    checkVal("T6 no change", chg_valid, 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      doCycle(($urandom % 100) < 30, int'($urandom % 8),
              ($urandom % 100) < 15, int'($urandom % 16),
              ($urandom % 100) < 5, ($urandom % 2) == 1);
    end
    clearOut();

    // Asynchronous reset while change is being offered.
    coin(4); coin(4);
    doCycle(0, 0, 0, 0, 1, 0);
    checkVal("T1 pre valid", chg_valid, 1);
    #2 cancelReset = 1'b1;
    #1;
    checkVal("T1 chg_valid", chg_valid, 0);
    checkVal("T1 credit", credit, 0);
    modelReset();
    @(negedge clk);
    cancelReset = 1'b0;
    idle(1);
    checkVal("T1 idle credit", credit, 0);
    coin(2);
    checkVal("T1 fresh coin", credit, 25);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
